// File: rtl/vector_writer.sv
// vector_writer: latches one packed vector and writes it out one element per clock at strided addresses.
module vector_writer #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 17,
  parameter int VECTOR_DIMENSION = 3,
  parameter int ADDR_STRIDE      = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enabled,
  input  logic [ELEMENT_WIDTH*VECTOR_DIMENSION-1:0] vector_in,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic                                  vector_valid,
  output logic                                  vector_ready,
  output logic [ADDR_WIDTH-1:0]                 addr,
  output logic [ELEMENT_WIDTH-1:0]              element_out,
  output logic                                  write_en,
  output logic                                  done
);
  localparam int IW = VECTOR_DIMENSION > 1 ? $clog2(VECTOR_DIMENSION) : 1;
  localparam logic [IW-1:0] LAST = IW'(VECTOR_DIMENSION - 1);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [ELEMENT_WIDTH*VECTOR_DIMENSION-1:0] vec_q, vec_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n, addr_n;
  logic [ELEMENT_WIDTH-1:0] element_n;
  logic write_en_n, done_n, ready_n;
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    vec_n      = vec_q;
    base_n     = base_q;
    addr_n     = addr;
    element_n  = element_out;
    write_en_n = 1'b0;
    done_n     = 1'b0;
    ready_n    = 1'b0;
    case (state)
      IDLE:
        if (vector_valid && vector_ready) begin
          state_n = WRITE;
          idx_n   = '0;
          vec_n   = vector_in;
          base_n  = base_addr;
        end else ready_n = 1'b1;
      WRITE:
        if (enabled) begin
          addr_n     = base_q + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
          element_n  = vec_q[int'(idx)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
          write_en_n = 1'b1;
          idx_n      = idx + 1'b1;
          state_n    = idx == LAST ? DONE : WRITE;
        end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      vec_q        <= '0;
      base_q       <= '0;
      addr         <= '0;
      element_out  <= '0;
      write_en     <= 1'b0;
      done         <= 1'b0;
      vector_ready <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      vec_q        <= vec_n;
      base_q       <= base_n;
      addr         <= addr_n;
      element_out  <= element_n;
      write_en     <= write_en_n;
      done         <= done_n;
      vector_ready <= ready_n;
    end
  end
endmodule
